// File: rtl/rotate_cmd_queue_pkg.sv
// Shared definitions for barrel_shifter users: word widths and the
// command record that travels through the rotate command queue.
package rotate_cmd_queue_pkg;

    localparam int DATA_W = 4;
    localparam int AMT_W  = 2;

    // Direction encoding as seen by barrel_shifter
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [AMT_W-1:0]  amt_t;

    // One queued rotate request: word, direction, distance
    typedef struct packed {
        data_t data;
        logic  dir;
        amt_t  amt;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Pack the loose command fields into a queue record
    function automatic cmd_t pack_cmd(input data_t data, input logic dir, input amt_t amt);
        cmd_t c;
        c.data = data;
        c.dir  = dir;
        c.amt  = amt;
        return c;
    endfunction

endpackage

// File: rtl/rotate_cmd_queue_barrel_shifter.sv
// Combinational 4-bit rotator. dir = 1 rotates right, dir = 0 rotates left;
// a distance of zero passes the word through unchanged.
module barrel_shifter
    import rotate_cmd_queue_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic              dir,
    input  logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] result
);

    logic [2*DATA_W-1:0] dbl_s;
    logic [2*DATA_W-1:0] shr_s;
    logic [2*DATA_W-1:0] shl_s;

    // Rotate by shifting a doubled copy of the word and keeping one half
    always_comb begin
        dbl_s  = {data, data};
        shr_s  = dbl_s >> amt;
        shl_s  = dbl_s << amt;
        result = data;
        case (dir)
            DIR_RIGHT: result = shr_s[DATA_W-1:0];
            DIR_LEFT:  result = shl_s[2*DATA_W-1:DATA_W];
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/rotate_cmd_queue.sv
// Rotate command queue: a DEPTH-entry FIFO of rotate requests feeding a
// barrel_shifter whose result is captured in a registered output stage.
// The FIFO level excludes the output register, so the block holds up to
// DEPTH + 1 commands in total.
module rotate_cmd_queue
    import rotate_cmd_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_dir,
    input  logic [AMT_W-1:0]         in_amt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] ZERO_LVL = LVL_W'(0);

    cmd_t              mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic              overflow_r;
    logic              out_valid_r;
    data_t             out_data_r;

    logic              in_ready_s;
    logic              push_s;
    logic              pop_s;
    cmd_t              head_s;
    data_t             rot_s;

    // Handshake decode: accept when not full, pop when the output stage can take a word
    always_comb begin
        in_ready_s = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        head_s     = mem_r[rd_ptr_r];
        if (level_r != FULL_LVL) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        push_s = in_valid & in_ready_s;
        if ((level_r != ZERO_LVL) && (!out_valid_r || out_ready)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    barrel_shifter u_shifter (
        .data   (head_s.data),
        .dir    (head_s.dir),
        .amt    (head_s.amt),
        .result (rot_s)
    );

    // FIFO storage write; contents are don't-care until a slot is pushed
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= pack_cmd(in_data, in_dir, in_amt);
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            level_r  <= ZERO_LVL;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Output stage: load the rotated head on a pop, drop the word once consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (pop_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= rot_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
        end
    end

    // Sticky overflow: a command offered while full is dropped and flagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (in_valid && !in_ready_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign level     = level_r;
    assign overflow  = overflow_r;

endmodule

// File: doc/rotate_cmd_queue.md
ROTATE_CMD_QUEUE -- requirements
Module: rotate_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 SHALL have clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have in_valid, input, 1, command present.
REQ-005 SHALL have in_ready, output, 1, queue accepts command this cycle.
REQ-006 SHALL have in_data, input, 4, word to rotate.
REQ-007 SHALL have in_dir, input, 1, 1 = rotate right, 0 = rotate left (barrel_shifter direction encoding).
REQ-008 SHALL have in_amt, input, 2, rotate distance 0..3.
REQ-009 SHALL have out_valid, output, 1, result present.
REQ-010 SHALL have out_ready, input, 1, consumer takes result.
REQ-011 SHALL have out_data, output, 4, rotated word, registered.
REQ-012 SHALL have level, output, clog2(DEPTH)+1, current FIFO occupancy, excluding the output register.
REQ-013 SHALL have overflow, output, 1, sticky flag: in_valid seen while in_ready low.

Function
REQ-014 SHALL accept a command on a clock edge where in_valid and in_ready are both high, storing {in_data, in_dir, in_amt} at the FIFO tail.
REQ-015 SHALL drive in_ready = (level != DEPTH); no same-cycle pass-through when full.
REQ-016 SHALL pop the FIFO head when level != 0 and (out_valid == 0 or out_ready == 1).
REQ-017 SHALL load out_data with the head word rotated per its dir/amt on each pop and set out_valid.
REQ-018 SHALL clear out_valid on an edge where out_valid and out_ready are high and no pop occurs.
REQ-019 SHALL provide latency of exactly 2 edges from acceptance to out_valid when the FIFO and output register are both empty; no bypass path.
REQ-020 SHALL sustain one command per cycle when out_ready is held high.
REQ-021 SHALL, on simultaneous push and pop, leave level unchanged, including at level == DEPTH-1.
REQ-022 SHALL hold out_data and out_valid stable while out_valid high and out_ready low.
REQ-023 SHALL wrap read and write pointers modulo DEPTH, with level tracked separately to distinguish full from empty.
REQ-024 SHALL treat in_amt == 0 as pass-through (out_data = in_data) for either direction.
REQ-025 SHALL set overflow on any edge with in_valid high and in_ready low, dropping that command; overflow is cleared only by rst.

Reset
REQ-026 SHALL, while rst is high, force out_valid=0, out_data=0, level=0, overflow=0, and both pointers to 0, independent of clk.
REQ-027 SHALL discard all queued commands and any held result on rst asserted mid-operation; FIFO storage contents need not be cleared.
REQ-028 SHALL drive in_ready high on the first edge after rst deasserts.

Structure
REQ-029 SHALL place the data width (4), amount width (2), and command-record field layout in the shared package used by barrel_shifter users.
REQ-030 SHALL instantiate the existing barrel_shifter combinationally between the FIFO head and the output register; it contains no other sub-module.

Verification
REQ-031 SHALL cover basic latency: push in_data=0110, dir=1, amt=1, with out_ready=1 -> out_data=0011, out_valid high 2 edges after acceptance.
REQ-032 SHALL cover left rotation: push 0110, dir=0, amt=1 -> 1100; push 1001, dir=0, amt=3 -> 1100.
REQ-033 SHALL cover fill and backpressure: out_ready=0, push 5 commands -> 4 queued plus 1 held; in_ready low when level=4; then out_ready=1 -> results drain in order.
REQ-034 SHALL cover overflow: with full FIFO, hold in_valid=1 for 1 cycle -> overflow=1, command absent from output, overflow stays 1 until rst.
REQ-035 SHALL cover streaming: 16 back-to-back pushes, out_ready=1 -> 16 results on consecutive cycles, level never exceeds 1.
REQ-036 SHALL cover mid-operation reset: assert rst with 3 queued -> out_valid=0 and level=0 immediately, no stale output after release.
